io_input_ctrl: RTL and testbench
================================

IO_INPUT_CTRL -- requirements
Module: io_input_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, giving the cycles an input must hold stable before it is accepted.
REQ-002 The block SHALL have parameter NUM_KEYS, default 4, giving the number of push-button inputs.
REQ-003 clock  in  1  single clock; every flop SHALL be on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 addr  in  32  CPU byte address; the block SHALL decode addr[7:2] only and SHALL respond only when addr[7]=1.
REQ-006 rd  in  1  read strobe, one cycle.
REQ-007 we  in  1  write strobe, one cycle.
REQ-008 datain  in  32  CPU write data.
REQ-009 sw  in  10  raw asynchronous slide switches.
REQ-010 key  in  NUM_KEYS  raw asynchronous push-buttons, active-low.
REQ-011 io_read_data  out  32  registered read data.
REQ-012 irq  out  1  level interrupt request.

Function
REQ-013 Each sw and key bit SHALL pass through a 2-flop synchronizer and then a per-bit debouncer.
REQ-014 The debouncer SHALL accept a new level only after the synchronized input differs from the accepted level for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart its counter at 0.
REQ-015 Key levels SHALL be inverted after debouncing, so that 1 means pressed.
REQ-016 The edge-capture register SHALL set bit i on a debounced 0->1 transition of key i (press).
REQ-017 Address map, addr[7:2], reads:
- 110000 = {27'b0, sw[4:0]}
- 110001 = {27'b0, sw[9:5]}
- 110010 = key level
- 110011 = edge capture
- 110100 = status {30'b0, any_edge, sw_changed}
- any other IO address SHALL read 0.
REQ-018 io_read_data SHALL update on the clock edge that samples rd=1 and SHALL hold its value while rd=0.
REQ-019 A write to 110011 SHALL clear each edge bit whose datain bit is 1 (write-1-to-clear); writes to any other address SHALL be ignored.
REQ-020 When a set event and a clear of the same bit occur in one cycle, the set SHALL win.
REQ-021 sw_changed SHALL set when any debounced sw bit changes and SHALL clear on a read of 110100, with set winning over the clear.
REQ-022 With rd and we high in the same cycle, the read SHALL return the pre-write value.

Reset
REQ-023 Reset SHALL clear the synchronizers, debounce counters, edge capture, sw_changed, mask and io_read_data to 0, and SHALL drive irq to 0.
REQ-024 Debounced key levels SHALL reset to released; debounced sw levels SHALL reset to 0.
REQ-025 A reset asserted mid-debounce SHALL discard the pending count.

Configuration
REQ-026 With IO_INPUT_IRQ_EN defined:
- a mask register SHALL exist at 110101, read/write, bits [NUM_KEYS-1:0], reset 0;
- irq SHALL be registered as |(edge & mask).
REQ-027 Without IO_INPUT_IRQ_EN, irq SHALL be tied 0, and 110101 SHALL read 0 and ignore writes.

Structure
REQ-028 A shared package SHALL hold the addr[7:2] offset constants and the DEBOUNCE_CYCLES default.
REQ-029 Per-bit synchronization and debouncing SHALL be one sub-module, io_debounce, instantiated 10+NUM_KEYS times.

Verification (DEBOUNCE_CYCLES=8 for simulation)
REQ-030 Scenario 1: sw=10'b10110_01101 held 12 cycles, then read 110000 and 110001 -> 0x0000000D and 0x00000016.
REQ-031 Scenario 2: sw[0] toggles every 3 cycles for 30 cycles, then held at 1 -> the debounced level stays 0 until 8 stable cycles pass, then becomes 1.
REQ-032 Scenario 3: key[2] pressed (driven 0) for 20 cycles, then read 110011 -> 0x4; write 0x4 to 110011, then read -> 0x0.
REQ-033 Scenario 4: a key[1] press event coincides with a write of 0x2 to 110011 -> bit 1 remains 1.
REQ-034 Scenario 5 (IO_INPUT_IRQ_EN): write mask 0x1, then press key[0] -> irq=1; clear the edge -> irq=0 the next cycle; key[3] press alone -> irq stays 0.
REQ-035 Scenario 6: reset asserted for 1 cycle during a debounce count -> all reads return 0 and no edge is captured.

Source files
------------

// File: rtl/io_input_pkg.sv
// Shared constants for the input controller: register offsets (addr[7:2]) and defaults.
package io_input_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
    localparam int unsigned NUM_KEYS_DEF        = 4;
    localparam int unsigned NUM_SW              = 10;

    // Offsets all carry bit 5 set, which is addr[7], the IO-region select.
    localparam logic [5:0] OFF_SW_LO  = 6'b110000;
    localparam logic [5:0] OFF_SW_HI  = 6'b110001;
    localparam logic [5:0] OFF_KEY    = 6'b110010;
    localparam logic [5:0] OFF_EDGE   = 6'b110011;
    localparam logic [5:0] OFF_STATUS = 6'b110100;
    localparam logic [5:0] OFF_MASK   = 6'b110101;

    function automatic logic [5:0] reg_offset(input logic [31:0] addr);
        return addr[7:2];
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debouncer for one input bit.
module io_debounce
    import io_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt_q;
    logic          level_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
            // Any cycle matching the accepted level restarts the count.
            if (sync_q2 == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_q <= sync_q2;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/io_input_ctrl.sv
// Memory-mapped switch/push-button input controller with key edge capture.
// Define IO_INPUT_IRQ_EN to add the key interrupt mask register and a live irq output.
module io_input_ctrl
    import io_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned NUM_KEYS        = NUM_KEYS_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         addr,
    input  logic                rd,
    input  logic                we,
    input  logic [31:0]         datain,
    input  logic [NUM_SW-1:0]   sw,
    input  logic [NUM_KEYS-1:0] key,
    output logic [31:0]         io_read_data,
    output logic                irq
);

    logic [NUM_SW-1:0]   sw_db;
    logic [NUM_KEYS-1:0] key_db;
    logic [NUM_KEYS-1:0] key_level;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (1'b0)
        ) u_sw_db (
            .clock(clock),
            .reset(reset),
            .din  (sw[i]),
            .level(sw_db[i])
        );
    end

    // Keys are active-low, so the debouncer rests at 1 (released).
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (1'b1)
        ) u_key_db (
            .clock(clock),
            .reset(reset),
            .din  (key[i]),
            .level(key_db[i])
        );
    end

    assign key_level = ~key_db;

    logic [5:0]          offset;
    logic                rd_hit;
    logic                wr_hit;
    logic [NUM_SW-1:0]   sw_prev_q;
    logic [NUM_KEYS-1:0] key_prev_q;
    logic [NUM_KEYS-1:0] edge_q;
    logic [NUM_KEYS-1:0] edge_d;
    logic [NUM_KEYS-1:0] edge_clr;
    logic                sw_changed_q;
    logic                sw_changed_d;
    logic [31:0]         rd_mux;
    logic [31:0]         rdata_q;
    logic [31:0]         rdata_d;

    assign offset = reg_offset(addr);
    assign rd_hit = rd & addr[7];
    assign wr_hit = we & addr[7];

`ifdef IO_INPUT_IRQ_EN
    logic [NUM_KEYS-1:0] mask_q;
    logic [NUM_KEYS-1:0] mask_d;
    logic                irq_q;
    logic                irq_d;
`endif

    // Read mux sees only pre-edge state, so a same-cycle write is never visible.
    always_comb begin
        rd_mux = '0;
        case (offset)
            OFF_SW_LO:  rd_mux = {27'b0, sw_db[4:0]};
            OFF_SW_HI:  rd_mux = {27'b0, sw_db[9:5]};
            OFF_KEY:    rd_mux = 32'(key_level);
            OFF_EDGE:   rd_mux = 32'(edge_q);
            OFF_STATUS: rd_mux = {30'b0, |edge_q, sw_changed_q};
`ifdef IO_INPUT_IRQ_EN
            OFF_MASK:   rd_mux = 32'(mask_q);
`endif
            default:    rd_mux = '0;
        endcase
    end

    always_comb begin
        edge_clr     = '0;
        edge_d       = edge_q;
        sw_changed_d = sw_changed_q;
        rdata_d      = rdata_q;
        if (wr_hit && offset == OFF_EDGE) begin
            edge_clr = datain[NUM_KEYS-1:0];
        end
        // Press events are OR-ed in after the clear so they win.
        edge_d = (edge_q & ~edge_clr) | (key_level & ~key_prev_q);
        if (sw_db != sw_prev_q) begin
            sw_changed_d = 1'b1;
        end else if (rd_hit && offset == OFF_STATUS) begin
            sw_changed_d = 1'b0;
        end
        if (rd_hit) begin
            rdata_d = rd_mux;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sw_prev_q    <= '0;
            key_prev_q   <= '0;
            edge_q       <= '0;
            sw_changed_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            sw_prev_q    <= sw_db;
            key_prev_q   <= key_level;
            edge_q       <= edge_d;
            sw_changed_q <= sw_changed_d;
            rdata_q      <= rdata_d;
        end
    end

`ifdef IO_INPUT_IRQ_EN
    always_comb begin
        mask_d = mask_q;
        if (wr_hit && offset == OFF_MASK) begin
            mask_d = datain[NUM_KEYS-1:0];
        end
        // Built from next-state so a clear drops irq on the same edge it lands.
        irq_d = |(edge_d & mask_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign io_read_data = rdata_q;

endmodule

// File: tb/tb_io_input_ctrl.sv
// Self-checking bench for io_input_ctrl: directed tables and scenarios plus random stimulus
// compared every cycle against a history-based behavioural model.
module tb_io_input_ctrl;
    import io_input_pkg::*;

    localparam int unsigned DB = 8;
    localparam int unsigned NK = 4;

    logic          clock  = 1'b0;
    logic          reset  = 1'b1;
    logic [31:0]   addr   = '0;
    logic          rd     = 1'b0;
    logic          we     = 1'b0;
    logic [31:0]   datain = '0;
    logic [9:0]    sw     = '0;
    logic [NK-1:0] key    = '1;
    logic [31:0]   io_read_data;
    logic          irq;

    always #5 clock = ~clock;

    io_input_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .NUM_KEYS       (NK)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .addr        (addr),
        .rd          (rd),
        .we          (we),
        .datain      (datain),
        .sw          (sw),
        .key         (key),
        .io_read_data(io_read_data),
        .irq         (irq)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bits 0..9 are sw, 10..13 are keys. A level is accepted once the last DB
    // synchronized samples all disagree with it.
    logic [13:0]   m_s1 = '0;
    logic [13:0]   m_s2 = '0;
    logic [13:0]   m_lvl = '0;
    logic [DB-1:0] m_hist [14];
    logic [9:0]    m_sw_prev = '0;
    logic [NK-1:0] m_key_prev = '0;
    logic [NK-1:0] m_edge = '0;
    logic [NK-1:0] m_mask = '0;
    logic          m_swc = 1'b0;
    logic          m_irq = 1'b0;
    logic [31:0]   m_rdata = '0;

    function automatic logic [31:0] m_read(input logic [5:0] off);
        logic [9:0]    swl;
        logic [NK-1:0] kp;
        swl = m_lvl[9:0];
        kp  = ~m_lvl[13:10];
        case (off)
            6'h30:   return {27'b0, swl[4:0]};
            6'h31:   return {27'b0, swl[9:5]};
            6'h32:   return {28'b0, kp};
            6'h33:   return {28'b0, m_edge};
            6'h34:   return {30'b0, |m_edge, m_swc};
`ifdef IO_INPUT_IRQ_EN
            6'h35:   return {28'b0, m_mask};
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clock) begin : model
        logic [NK-1:0] kp;
        logic [NK-1:0] clr;
        logic [9:0]    swl;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_lvl = {4'hF, 10'h000};
            m_sw_prev = '0; m_key_prev = '0; m_edge = '0; m_mask = '0;
            m_swc = 1'b0; m_irq = 1'b0; m_rdata = '0;
            for (int i = 0; i < 14; i++) m_hist[i] = {DB{m_lvl[i]}};
        end else begin
            swl = m_lvl[9:0];
            kp  = ~m_lvl[13:10];
            if (rd && addr[7]) m_rdata = m_read(addr[7:2]);
            clr = (we && addr[7:2] == 6'h33) ? datain[NK-1:0] : '0;
            m_edge = (m_edge & ~clr) | (kp & ~m_key_prev);
            if (swl != m_sw_prev) m_swc = 1'b1;
            else if (rd && addr[7:2] == 6'h34) m_swc = 1'b0;
`ifdef IO_INPUT_IRQ_EN
            if (we && addr[7:2] == 6'h35) m_mask = datain[NK-1:0];
            m_irq = |(m_edge & m_mask);
`endif
            m_key_prev = kp;
            m_sw_prev  = swl;
            for (int i = 0; i < 14; i++) begin
                m_hist[i] = {m_hist[i][DB-2:0], m_s2[i]};
                if (m_hist[i] == {DB{~m_lvl[i]}}) m_lvl[i] = ~m_lvl[i];
            end
            m_s2 = m_s1;
            m_s1 = {key, sw};
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("model_rdata", io_read_data, m_rdata);
            check("model_irq", {31'b0, irq}, {31'b0, m_irq});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_read(input logic [5:0] off, output logic [31:0] d);
        addr = {24'h0, off, 2'b00};
        rd   = 1'b1;
        tick(1);
        rd = 1'b0;
        d  = io_read_data;
    endtask

    task automatic do_write(input logic [5:0] off, input logic [31:0] data);
        addr   = {24'h0, off, 2'b00};
        datain = data;
        we     = 1'b1;
        tick(1);
        we = 1'b0;
    endtask

    typedef struct {
        logic [9:0]  sw_val;
        logic [5:0]  off;
        logic [31:0] exp;
    } sw_vec_t;

    sw_vec_t sw_tab [12];
    logic [5:0] rst_offs [6];

    initial begin
        logic [31:0] d;
        sw_tab[0]  = '{10'b1011001101, 6'h30, 32'h0000000D};
        sw_tab[1]  = '{10'b1011001101, 6'h31, 32'h00000016};
        sw_tab[2]  = '{10'h3FF, 6'h30, 32'h0000001F};
        sw_tab[3]  = '{10'h3FF, 6'h31, 32'h0000001F};
        sw_tab[4]  = '{10'h3FF, 6'h36, 32'h00000000};
        sw_tab[5]  = '{10'h2AA, 6'h30, 32'h0000000A};
        sw_tab[6]  = '{10'h2AA, 6'h31, 32'h00000015};
        sw_tab[7]  = '{10'h2AA, 6'h3F, 32'h00000000};
        sw_tab[8]  = '{10'h155, 6'h30, 32'h00000015};
        sw_tab[9]  = '{10'h155, 6'h31, 32'h0000000A};
        sw_tab[10] = '{10'h000, 6'h34, 32'h00000001};
        sw_tab[11] = '{10'h000, 6'h34, 32'h00000000};
        rst_offs   = '{6'h31, 6'h32, 6'h33, 6'h34, 6'h35, 6'h30};

        tick(2);
        reset = 1'b0;
        check("reset_rdata", io_read_data, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        chk_en = 1'b1;

        // Switch patterns held 12 cycles, then read.
        foreach (sw_tab[i]) begin
            sw = sw_tab[i].sw_val;
            tick(12);
            do_read(sw_tab[i].off, d);
            check($sformatf("sw_tab[%0d]", i), d, sw_tab[i].exp);
        end

        // sw[0] bounces every 3 cycles, then holds 1: 2 sync + 8 stable cycles to accept.
        for (int seg = 0; seg < 10; seg++) begin
            sw[0] = (seg % 2 == 0);
            for (int c = 0; c < 3; c++) begin
                do_read(6'h30, d);
                check("bounce_level", {31'b0, d[0]}, 32'h0);
            end
        end
        sw[0] = 1'b1;
        for (int t = 0; t < 15; t++) begin
            do_read(6'h30, d);
            check($sformatf("settle_t%0d", t), {31'b0, d[0]}, {31'b0, t >= 10});
        end
        sw[0] = 1'b0;
        tick(12);
        do_read(6'h34, d);

        // key[2] press, edge capture, rd+we same cycle, W1C.
        key[2] = 1'b0;
        tick(20);
        do_read(6'h33, d);
        check("key2_edge", d, 32'h4);
        do_read(6'h32, d);
        check("key2_level", d, 32'h4);
        addr = {24'h0, 6'h33, 2'b00}; datain = 32'h4; rd = 1'b1; we = 1'b1;
        tick(1);
        rd = 1'b0; we = 1'b0;
        check("rdwe_prewrite", io_read_data, 32'h4);
        do_read(6'h33, d);
        check("key2_cleared", d, 32'h0);
        key[2] = 1'b1;
        tick(12);

        // key[1] press lands on the same edge as a W1C of bit 1; set wins.
        do_write(6'h33, 32'hF);
        key[1] = 1'b0;
        tick(10);
        do_write(6'h33, 32'h2);
        do_read(6'h33, d);
        check("set_wins", d, 32'h2);
        do_write(6'h33, 32'h2);
        key[1] = 1'b1;
        tick(12);

`ifdef IO_INPUT_IRQ_EN
        do_write(6'h35, 32'h1);
        do_read(6'h35, d);
        check("mask_read", d, 32'h1);
        key[0] = 1'b0;
        tick(12);
        check("irq_set", {31'b0, irq}, 32'h1);
        do_write(6'h33, 32'h1);
        check("irq_clear", {31'b0, irq}, 32'h0);
        key[0] = 1'b1;
        tick(12);
        key[3] = 1'b0;
        tick(12);
        check("irq_masked", {31'b0, irq}, 32'h0);
        do_read(6'h33, d);
        check("key3_edge", d, 32'h8);
        key[3] = 1'b1;
        do_write(6'h33, 32'hF);
        do_write(6'h35, 32'h0);
        tick(12);
`else
        do_write(6'h35, 32'hF);
        do_read(6'h35, d);
        check("mask_absent", d, 32'h0);
        key[0] = 1'b0;
        tick(12);
        check("irq_tied", {31'b0, irq}, 32'h0);
        key[0] = 1'b1;
        do_write(6'h33, 32'hF);
        tick(12);
`endif

        // Reset in the middle of sw[3] and key[1] debounce counts.
        do_read(6'h34, d);
        sw[3]  = 1'b1;
        key[1] = 1'b0;
        tick(6);
        reset  = 1'b1;
        key[1] = 1'b1;
        tick(1);
        reset = 1'b0;
        foreach (rst_offs[i]) begin
            do_read(rst_offs[i], d);
            check($sformatf("post_reset_%0h", rst_offs[i]), d, 32'h0);
        end
        tick(6);
        do_read(6'h30, d);
        check("post_reset_sw3", d, 32'h8);
        do_read(6'h33, d);
        check("post_reset_noedge", d, 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 10; b++) if ($urandom_range(0, 29) == 0) sw[b] = ~sw[b];
            for (int b = 0; b < NK; b++) if ($urandom_range(0, 29) == 0) key[b] = ~key[b];
            addr   = {$urandom_range(0, 255) << 8} | {24'h0, 3'b110, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            rd     = ($urandom_range(0, 2) == 0);
            we     = ($urandom_range(0, 3) == 0);
            datain = $urandom;
            reset  = (c == 700);
            tick(1);
        end
        rd = 1'b0; we = 1'b0; reset = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
